// File: rtl/alu_share_arbiter_pkg.sv
// Shared definitions for the ALU share arbiter: ALU control codes, port ids,
// default widths and the legal-opcode check.
package alu_share_arbiter_pkg;

  localparam int unsigned WIDTH_DEF  = 32;
  localparam int unsigned CTRL_W_DEF = 4;

  localparam logic [3:0] ALU_AND = 4'h0;
  localparam logic [3:0] ALU_OR  = 4'h1;
  localparam logic [3:0] ALU_ADD = 4'h2;
  localparam logic [3:0] ALU_XOR = 4'h3;
  localparam logic [3:0] ALU_SLL = 4'h4;
  localparam logic [3:0] ALU_SRL = 4'h5;
  localparam logic [3:0] ALU_SUB = 4'h6;
  localparam logic [3:0] ALU_SLT = 4'h7;
  localparam logic [3:0] ALU_SRA = 4'h8;
  localparam logic [3:0] ALU_BEQ = 4'h9;
  localparam logic [3:0] ALU_BNE = 4'hA;
  localparam logic [3:0] ALU_NOR = 4'hC;

  typedef enum logic {
    PORT_EX  = 1'b0,
    PORT_SEQ = 1'b1
  } port_e;

  function automatic logic alu_op_legal(input logic [CTRL_W_DEF-1:0] ctrl);
    case (ctrl)
      ALU_AND, ALU_OR, ALU_ADD, ALU_XOR, ALU_SLL, ALU_SRL,
      ALU_SUB, ALU_SLT, ALU_SRA, ALU_BEQ, ALU_BNE, ALU_NOR: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_share_arbiter_if.sv
// Request/response and ALU-side signals of the ALU share arbiter.
// slave = arbiter view, master = requesters plus external ALU.
interface alu_share_arbiter_if
  import alu_share_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH  = WIDTH_DEF,
  parameter int unsigned CTRL_W = CTRL_W_DEF
) ();

  logic [1:0]        req_valid;
  logic [1:0]        req_ready;
  logic [WIDTH-1:0]  req_a0, req_a1;
  logic [WIDTH-1:0]  req_b0, req_b1;
  logic [CTRL_W-1:0] req_ctrl0, req_ctrl1;
  logic [WIDTH-1:0]  alu_a, alu_b;
  logic [CTRL_W-1:0] alu_ctrl;
  logic [WIDTH-1:0]  alu_c;
  logic              alu_zero;
  logic [1:0]        rsp_valid;
  logic [1:0]        rsp_ready;
  logic [WIDTH-1:0]  rsp_data0, rsp_data1;
  logic              rsp_zero0, rsp_zero1;
  logic              rsp_err0, rsp_err1;

  modport slave (
    input  req_valid, req_a0, req_a1, req_b0, req_b1, req_ctrl0, req_ctrl1,
    input  alu_c, alu_zero, rsp_ready,
    output req_ready, alu_a, alu_b, alu_ctrl,
    output rsp_valid, rsp_data0, rsp_data1, rsp_zero0, rsp_zero1, rsp_err0, rsp_err1
  );

  modport master (
    output req_valid, req_a0, req_a1, req_b0, req_b1, req_ctrl0, req_ctrl1,
    output alu_c, alu_zero, rsp_ready,
    input  req_ready, alu_a, alu_b, alu_ctrl,
    input  rsp_valid, rsp_data0, rsp_data1, rsp_zero0, rsp_zero1, rsp_err0, rsp_err1
  );

endinterface

// File: rtl/alu_share_arbiter_rr_arb2.sv
// Two-way grant logic: round-robin with a last-winner pointer, or fixed
// priority to port 0 with a saturating wait counter that forces port 1 through.
module rr_arb2
  import alu_share_arbiter_pkg::*;
#(
  parameter int unsigned PRIO_MODE = 0,
  parameter int unsigned MAX_WAIT  = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] i_elig,
  output logic [1:0] o_grant
);

  localparam int unsigned CNT_W = $clog2(MAX_WAIT + 1);
  typedef logic [CNT_W-1:0] cnt_t;
  localparam cnt_t CNT_MAX = cnt_t'(MAX_WAIT);

  port_e r_ptr;
  cnt_t  r_wait;

  always_comb begin
    o_grant = i_elig;
    if (i_elig == 2'b11) begin
      if (PRIO_MODE == 0) o_grant = (r_ptr == PORT_EX) ? 2'b10 : 2'b01;
      else                o_grant = (r_wait == CNT_MAX) ? 2'b10 : 2'b01;
    end
  end

  // Wait count is not cleared while port 1 is idle; it only resets on a port 1 grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr  <= PORT_EX;
      r_wait <= '0;
    end else begin
      if (o_grant[1])      r_ptr <= PORT_SEQ;
      else if (o_grant[0]) r_ptr <= PORT_EX;

      if (o_grant[1])                            r_wait <= '0;
      else if (i_elig[1] && (r_wait != CNT_MAX)) r_wait <= r_wait + cnt_t'(1);
    end
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one external combinational ALU between the EX stage (port 0) and the
// mul/div/shift sequencer (port 1): issue register plus one response slot per port.
module alu_share_arbiter
  import alu_share_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH     = WIDTH_DEF,
  parameter int unsigned CTRL_W    = CTRL_W_DEF,
  parameter int unsigned PRIO_MODE = 0,
  parameter int unsigned MAX_WAIT  = 4
) (
  input logic               clk,
  input logic               rst_n,
  alu_share_arbiter_if.slave bus
);

  logic [1:0]        w_elig, w_grant, w_capture;
  logic              r_iss_valid;
  port_e             r_iss_port;
  logic [WIDTH-1:0]  r_alu_a, r_alu_b;
  logic [CTRL_W-1:0] r_alu_ctrl;
  logic [1:0]        r_rsp_valid, r_rsp_zero, r_rsp_err;
  logic [WIDTH-1:0]  r_rsp_data [2];
  logic              w_legal, w_is_branch, w_res_zero;
  logic [WIDTH-1:0]  w_res_data;

  // One outstanding op per port, so a granted op always finds its slot free.
  assign w_elig[0] = bus.req_valid[0] && !(r_iss_valid && (r_iss_port == PORT_EX))
                     && (!r_rsp_valid[0] || bus.rsp_ready[0]);
  assign w_elig[1] = bus.req_valid[1] && !(r_iss_valid && (r_iss_port == PORT_SEQ))
                     && (!r_rsp_valid[1] || bus.rsp_ready[1]);

  rr_arb2 #(
    .PRIO_MODE (PRIO_MODE),
    .MAX_WAIT  (MAX_WAIT)
  ) u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_elig  (w_elig),
    .o_grant (w_grant)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_iss_valid <= 1'b0;
      r_iss_port  <= PORT_EX;
      r_alu_a     <= '0;
      r_alu_b     <= '0;
      r_alu_ctrl  <= CTRL_W'(ALU_ADD);
    end else if (w_grant[1]) begin
      r_iss_valid <= 1'b1;
      r_iss_port  <= PORT_SEQ;
      r_alu_a     <= bus.req_a1;
      r_alu_b     <= bus.req_b1;
      r_alu_ctrl  <= bus.req_ctrl1;
    end else if (w_grant[0]) begin
      r_iss_valid <= 1'b1;
      r_iss_port  <= PORT_EX;
      r_alu_a     <= bus.req_a0;
      r_alu_b     <= bus.req_b0;
      r_alu_ctrl  <= bus.req_ctrl0;
    end else begin
      r_iss_valid <= 1'b0;
    end
  end

  assign w_legal     = alu_op_legal(r_alu_ctrl);
  assign w_is_branch = (r_alu_ctrl == CTRL_W'(ALU_BEQ)) || (r_alu_ctrl == CTRL_W'(ALU_BNE));
  assign w_res_data  = w_legal ? bus.alu_c : '0;
  assign w_res_zero  = w_is_branch && bus.alu_zero;
  assign w_capture[0] = r_iss_valid && (r_iss_port == PORT_EX);
  assign w_capture[1] = r_iss_valid && (r_iss_port == PORT_SEQ);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_valid <= '0;
      r_rsp_zero  <= '0;
      r_rsp_err   <= '0;
      for (int unsigned i = 0; i < 2; i++) r_rsp_data[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < 2; i++) begin
        if (w_capture[i]) begin
          r_rsp_valid[i] <= 1'b1;
          r_rsp_data[i]  <= w_res_data;
          r_rsp_zero[i]  <= w_res_zero;
          r_rsp_err[i]   <= !w_legal;
        end else if (bus.rsp_ready[i]) begin
          r_rsp_valid[i] <= 1'b0;
        end
      end
    end
  end

  assign bus.req_ready = w_grant;
  assign bus.alu_a     = r_alu_a;
  assign bus.alu_b     = r_alu_b;
  assign bus.alu_ctrl  = r_alu_ctrl;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_data0 = r_rsp_data[0];
  assign bus.rsp_data1 = r_rsp_data[1];
  assign bus.rsp_zero0 = r_rsp_zero[0];
  assign bus.rsp_zero1 = r_rsp_zero[1];
  assign bus.rsp_err0  = r_rsp_err[0];
  assign bus.rsp_err1  = r_rsp_err[1];

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: round-robin instance with a response scoreboard,
// plus a fixed-priority instance for the anti-starvation grant sequence.
module tb_alu_share_arbiter;
  import alu_share_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic [31:0] d;
    logic        z;
    logic        e;
  } exp_t;
  exp_t q0[$];
  exp_t q1[$];

  // Round-robin instance
  alu_share_arbiter_if #(.WIDTH(32), .CTRL_W(4)) if0 ();
  alu_share_arbiter #(.WIDTH(32), .CTRL_W(4), .PRIO_MODE(0), .MAX_WAIT(4)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .bus(if0.slave));

  // Fixed-priority instance
  alu_share_arbiter_if #(.WIDTH(32), .CTRL_W(4)) if1 ();
  alu_share_arbiter #(.WIDTH(32), .CTRL_W(4), .PRIO_MODE(1), .MAX_WAIT(4)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .bus(if1.slave));

  logic        v0 = 0, v1 = 0, r0 = 0, r1 = 0;
  logic [31:0] a0 = 0, b0 = 0, a1 = 0, b1 = 0;
  logic [3:0]  c0 = 0, c1 = 0;
  logic        p0v = 0, p1v = 0;
  logic        log_en = 0;
  logic [1:0]  glog[$];

  assign if0.req_valid = {v1, v0};
  assign if0.req_a0 = a0;  assign if0.req_b0 = b0;  assign if0.req_ctrl0 = c0;
  assign if0.req_a1 = a1;  assign if0.req_b1 = b1;  assign if0.req_ctrl1 = c1;
  assign if0.rsp_ready = {r1, r0};

  assign if1.req_valid = {p1v, p0v};
  assign if1.req_a0 = 32'd1;  assign if1.req_b0 = 32'd1;  assign if1.req_ctrl0 = ALU_ADD;
  assign if1.req_a1 = 32'd2;  assign if1.req_b1 = 32'd2;  assign if1.req_ctrl1 = ALU_ADD;
  assign if1.rsp_ready = 2'b11;
  assign if1.alu_c = '0;
  assign if1.alu_zero = 1'b0;

  // External ALU behaviour; illegal codes produce junk to prove the masking.
  function automatic logic [32:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                            input logic [3:0] ctrl);
    logic [31:0] c;
    logic        z;
    case (ctrl)
      4'h0: c = a & b;
      4'h1: c = a | b;
      4'h2: c = a + b;
      4'h3: c = a ^ b;
      4'h4: c = b << a[4:0];
      4'h5: c = b >> a[4:0];
      4'h6: c = a - b;
      4'h7: c = {31'b0, $signed(a) < $signed(b)};
      4'h8: c = $signed(b) >>> a[4:0];
      4'h9: c = {31'b0, a == b};
      4'hA: c = {31'b0, a != b};
      4'hC: c = ~(a | b);
      default: c = 32'hDEAD_BEEF;
    endcase
    if (ctrl == 4'h9 || ctrl == 4'hA) z = c[0];
    else if (alu_op_legal(ctrl))      z = (c == 32'd0);
    else                              z = 1'b1;
    return {z, c};
  endfunction

  logic [32:0] m0;
  assign m0 = alu_model(if0.alu_a, if0.alu_b, if0.alu_ctrl);
  assign if0.alu_c = m0[31:0];
  assign if0.alu_zero = m0[32];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic timeout_fail(input string name);
    n_checks++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  // Monitor: pops an expectation whenever a response handshake is taking place.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (if0.rsp_valid[0] && if0.rsp_ready[0]) begin
        if (q0.size() == 0) begin
          n_checks++;
          $display("FAIL rsp0_unexpected: got %0h with nothing expected", if0.rsp_data0);
        end else begin
          e = q0.pop_front();
          chk("rsp0", {30'b0, if0.rsp_err0, if0.rsp_zero0, if0.rsp_data0}, {30'b0, e.e, e.z, e.d});
        end
      end
      if (if0.rsp_valid[1] && if0.rsp_ready[1]) begin
        if (q1.size() == 0) begin
          n_checks++;
          $display("FAIL rsp1_unexpected: got %0h with nothing expected", if0.rsp_data1);
        end else begin
          e = q1.pop_front();
          chk("rsp1", {30'b0, if0.rsp_err1, if0.rsp_zero1, if0.rsp_data1}, {30'b0, e.e, e.z, e.d});
        end
      end
      if (log_en) glog.push_back(if0.req_ready);
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Raise a request, wait for its grant, and record the expected response.
  task automatic issue(input int p, input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] c, input logic [31:0] ed, input logic ez,
                       input logic ee);
    bit ok = 0;
    if (p == 0) begin a0 = a; b0 = b; c0 = c; v0 = 1; end
    else        begin a1 = a; b1 = b; c1 = c; v1 = 1; end
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (if0.req_ready[p]) begin ok = 1; break; end
    end
    if (!ok) timeout_fail("issue_grant");
    else if (p == 0) q0.push_back('{ed, ez, ee});
    else             q1.push_back('{ed, ez, ee});
    @(posedge clk);
    #1;
    if (p == 0) v0 = 0; else v1 = 0;
  endtask

  task automatic wait_rsp_valid(input int p, input string name);
    bit ok = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (if0.rsp_valid[p]) begin ok = 1; break; end
    end
    if (!ok) timeout_fail(name);
  endtask

  typedef struct {
    logic [31:0] a, b;
    logic [3:0]  c;
    logic [31:0] d;
    logic        z, e;
  } vec_t;
  vec_t vecs[$];

  logic [1:0] t4_exp [10];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle(2);
    rst_n = 1;
    idle(1);

    // Reset while a response is pending
    r0 = 0;
    issue(0, 32'd1, 32'd2, ALU_ADD, 32'd3, 0, 0);
    wait_rsp_valid(0, "t1_rsp_wait");
    chk("t1_valid_pre_reset", if0.rsp_valid[0], 1);
    @(posedge clk); #1;
    rst_n = 0;
    q0.delete();
    @(negedge clk);
    chk("t1_rsp_valid", if0.rsp_valid, 0);
    chk("t1_rsp_data0", if0.rsp_data0, 0);
    chk("t1_rsp_zero_err", {if0.rsp_zero0, if0.rsp_err0}, 0);
    chk("t1_alu_ctrl", if0.alu_ctrl, 2);
    chk("t1_alu_ab", {if0.alu_a, if0.alu_b}, 0);
    chk("t1_req_ready", if0.req_ready, 0);
    @(posedge clk); #1;
    rst_n = 1;
    r0 = 1; r1 = 1;
    @(negedge clk);
    chk("t1_discarded", if0.rsp_valid, 0);
    idle(1);

    // Latency: add 5+7
    issue(0, 32'd5, 32'd7, ALU_ADD, 32'd12, 0, 0);
    @(negedge clk);
    chk("t2_alu_ab", {if0.alu_a, if0.alu_b}, {32'd5, 32'd7});
    chk("t2_alu_ctrl", if0.alu_ctrl, 2);
    chk("t2_rsp_not_yet", if0.rsp_valid[0], 0);
    @(negedge clk);
    chk("t2_rsp_valid", if0.rsp_valid[0], 1);
    idle(3);

    // Both ports continuously active: alternating grants, ALU busy every cycle
    log_en = 1;
    fork
      begin
        for (int i = 0; i < 3; i++) issue(0, 32'd9, 32'd4, ALU_SUB, 32'd5, 0, 0);
      end
      begin
        for (int i = 0; i < 3; i++) issue(1, 32'hF0, 32'h0F, ALU_XOR, 32'hFF, 0, 0);
      end
    join
    log_en = 0;
    chk("t3_len", glog.size(), 6);
    if (glog.size() > 0) chk("t3_first", glog[0], 2'b10);
    for (int i = 1; i < glog.size(); i++)
      chk($sformatf("t3_alt%0d", i), glog[i], (glog[i-1] == 2'b01) ? 2'b10 : 2'b01);
    idle(3);

    // Held response on port 1 blocks a new request until the drain cycle
    r1 = 0;
    issue(1, 32'd3, 32'd3, ALU_BEQ, 32'd1, 1, 0);
    wait_rsp_valid(1, "t5_rsp_wait");
    @(posedge clk); #1;
    a1 = 32'd1; b1 = 32'd1; c1 = ALU_ADD; v1 = 1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("t5_ready_blocked", if0.req_ready[1], 0);
      chk("t5_held", {if0.rsp_valid[1], if0.rsp_zero1, if0.rsp_data1}, {1'b1, 1'b1, 32'd1});
      @(posedge clk); #1;
    end
    r1 = 1;
    @(negedge clk);
    chk("t5_drain_ready", if0.req_ready[1], 1);
    q1.push_back('{32'd2, 1'b0, 1'b0});
    @(posedge clk); #1;
    v1 = 0;
    idle(3);

    // Illegal code, then legal ops including zero-flag masking
    issue(0, 32'd3, 32'd4, 4'hF, 32'd0, 0, 1);
    issue(0, 32'd4, 32'd1, ALU_SLL, 32'd16, 0, 0);
    vecs.push_back('{32'hF0, 32'h3C, ALU_AND, 32'h30, 0, 0});
    vecs.push_back('{32'hF0, 32'h0F, ALU_OR, 32'hFF, 0, 0});
    vecs.push_back('{32'hFFFF_FFFF, 32'd2, ALU_SLT, 32'd1, 0, 0});
    vecs.push_back('{32'd4, 32'h8000_0000, ALU_SRA, 32'hF800_0000, 0, 0});
    vecs.push_back('{32'd4, 32'h8000_0000, ALU_SRL, 32'h0800_0000, 0, 0});
    vecs.push_back('{32'd0, 32'd0, ALU_NOR, 32'hFFFF_FFFF, 0, 0});
    vecs.push_back('{32'd5, 32'd5, ALU_SUB, 32'd0, 0, 0});
    vecs.push_back('{32'd3, 32'd4, ALU_BNE, 32'd1, 1, 0});
    vecs.push_back('{32'd3, 32'd4, ALU_BEQ, 32'd0, 0, 0});
    vecs.push_back('{32'd7, 32'd7, 4'hB, 32'd0, 0, 1});
    vecs.push_back('{32'd7, 32'd7, 4'hD, 32'd0, 0, 1});
    foreach (vecs[i]) issue(0, vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].d, vecs[i].z, vecs[i].e);
    idle(3);

    // Fixed priority: port 1 contends only when port 0 is eligible; 5th contention wins
    t4_exp = '{2'b01, 2'b00, 2'b01, 2'b00, 2'b01, 2'b00, 2'b01, 2'b00, 2'b10, 2'b01};
    p0v = 1; p1v = 1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk($sformatf("t4_grant%0d", k), if1.req_ready, t4_exp[k]);
      @(posedge clk); #1;
      p1v = ((k + 1) % 2 == 0);
    end
    p0v = 0; p1v = 0;

    for (int k = 0; k < 20 && (q0.size() != 0 || q1.size() != 0); k++) @(posedge clk);
    @(negedge clk);
    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
